// File: rtl/tdm_demux8.sv
// Receive side of an 8:1 time-division link: collects eight serial DW-bit samples
// framed by sof and publishes them as one held, acknowledged parallel frame.
module tdm_demux8 #(
  parameter int DW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   din,
  input  logic            in_valid,
  input  logic            sof,
  output logic [8*DW-1:0] ch_data,
  output logic            frame_valid,
  input  logic            frame_ack,
  output logic            busy,
  output logic [2:0]      slot,
  output logic            frame_err,
  output logic            drop_err,
  output logic            overrun
);

  localparam int NCH = 8;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                  state, state_n;
  logic [2:0]              slot_n;
  // Slot 7 never lands here: it goes straight to ch_data on the publish edge.
  logic [(NCH-1)*DW-1:0]   shadow, shadow_n;
  logic [NCH*DW-1:0]       ch_data_n;
  logic                    frame_valid_n;
  logic                    frame_err_n;
  logic                    drop_err_n;
  logic                    overrun_n;
  logic                    publish;

  // Output handshake: frame_valid rises on publish and stays high until a cycle
  // with frame_ack=1; ch_data only changes on publish, so it never tears.
  always_comb begin
    state_n       = state;
    slot_n        = slot;
    shadow_n      = shadow;
    ch_data_n     = ch_data;
    frame_valid_n = frame_valid;
    frame_err_n   = 1'b0;
    drop_err_n    = 1'b0;
    overrun_n     = 1'b0;
    publish       = 1'b0;

    if (frame_ack) frame_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (sof) begin
            shadow_n[DW-1:0] = din;
            slot_n           = 3'd1;
            state_n          = COLLECT;
          end else begin
            drop_err_n = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (sof) begin
            // Restart: stale slots of the aborted frame are rewritten before any publish.
            frame_err_n      = 1'b1;
            shadow_n[DW-1:0] = din;
            slot_n           = 3'd1;
          end else if (slot == 3'd7) begin
            publish = 1'b1;
            slot_n  = 3'd0;
            state_n = IDLE;
          end else begin
            for (int k = 0; k < NCH - 1; k++) begin
              if (slot == 3'(k)) shadow_n[k*DW +: DW] = din;
            end
            slot_n = slot + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (publish) begin
      ch_data_n     = {din, shadow};
      frame_valid_n = 1'b1;
      overrun_n     = frame_valid & ~frame_ack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= 3'd0;
      shadow      <= '0;
      ch_data     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      drop_err    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      shadow      <= shadow_n;
      ch_data     <= ch_data_n;
      frame_valid <= frame_valid_n;
      frame_err   <= frame_err_n;
      drop_err    <= drop_err_n;
      overrun     <= overrun_n;
    end
  end

  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: a DW=1 instance for framing/handshake behaviour
// and a DW=4 instance for multi-bit slot placement.
module tb_tdm_demux8;

  logic clk;
  logic rst_n;

  logic        din1, iv1, sof1, ack1;
  logic [7:0]  ch1;
  logic        fv1, busy1, ferr1, derr1, ovr1;
  logic [2:0]  slot1;

  logic [3:0]  din4;
  logic        iv4, sof4, ack4;
  logic [31:0] ch4;
  logic        fv4, busy4, ferr4, derr4, ovr4;
  logic [2:0]  slot4;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int pub_cnt  = 0;
  logic fv_prev = 1'b0;

  logic [31:0] exp_q[$];

  tdm_demux8 #(.DW(1)) u_dw1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .in_valid(iv1), .sof(sof1),
    .ch_data(ch1), .frame_valid(fv1), .frame_ack(ack1), .busy(busy1),
    .slot(slot1), .frame_err(ferr1), .drop_err(derr1), .overrun(ovr1)
  );

  tdm_demux8 #(.DW(4)) u_dw4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .in_valid(iv4), .sof(sof4),
    .ch_data(ch4), .frame_valid(fv4), .frame_ack(ack4), .busy(busy4),
    .slot(slot4), .frame_err(ferr4), .drop_err(derr4), .overrun(ovr4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor on the DW=1 instance, sampled away from the active edge
  always @(negedge clk) begin
    if (ferr1) ferr_cnt++;
    if (ovr1) ovr_cnt++;
    if (fv1 && !fv_prev) pub_cnt++;
    fv_prev = fv1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one cycle, inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic d, input logic s, input logic a);
    din1 = d; sof1 = s; iv1 = 1'b1; ack1 = a;
    tick();
    iv1 = 1'b0; sof1 = 1'b0; ack1 = 1'b0;
  endtask

  // Sends bits[k] as slot k; optional idle gaps; optional ack on the last sample
  task automatic send_frame(input string tag, input logic [7:0] bits, input int gap,
                            input logic ack_last);
    for (int k = 0; k < 8; k++) begin
      send1(bits[k], k == 0, (k == 7) && ack_last);
      for (int g = 0; g < gap && k < 7; g++) begin
        tick();
        check({tag, " busy_gap"}, {31'b0, busy1}, 32'd1);
      end
    end
    exp_q.push_back({24'b0, bits});
  endtask

  task automatic check_pub(input string tag, input logic [31:0] obs, input logic obs_fv);
    logic [31:0] exp;
    check({tag, " queue"}, exp_q.size(), 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
    check({tag, " ch_data"}, obs, exp);
    check({tag, " frame_valid"}, {31'b0, obs_fv}, 32'd1);
  endtask

  initial begin
    int f0, o0, p0;
    rst_n = 1'b0;
    din1 = 1'b0; iv1 = 1'b0; sof1 = 1'b0; ack1 = 1'b0;
    din4 = 4'h0; iv4 = 1'b0; sof4 = 1'b0; ack4 = 1'b0;
    repeat (3) tick();
    check("rst ch_data", {24'b0, ch1}, 32'h0);
    check("rst outs", {25'b0, fv1, busy1, slot1, ferr1, derr1, ovr1} , 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst busy/slot", {28'b0, busy1, slot1}, 32'h0);

    // Clean frame, then ack
    send_frame("clean", 8'h01, 0, 1'b0);
    check_pub("clean", {24'b0, ch1}, fv1);
    check("clean busy", {31'b0, busy1}, 32'd0);
    tick();
    check("clean fv_hold", {31'b0, fv1}, 32'd1);
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    check("clean acked", {31'b0, fv1}, 32'd0);
    check("clean data_kept", {24'b0, ch1}, 32'h01);

    // Ack while nothing is pending is ignored
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    check("idle_ack", {31'b0, fv1}, 32'd0);

    // Asynchronous reset in the middle of a frame
    send1(1'b1, 1'b1, 1'b0);
    send1(1'b0, 1'b0, 1'b0);
    send1(1'b1, 1'b0, 1'b0);
    check("mid busy/slot", {28'b0, busy1, slot1}, {28'b0, 1'b1, 3'd3});
    #2 rst_n = 1'b0;
    #1;
    check("async ch_data", {24'b0, ch1}, 32'h0);
    check("async busy/slot", {28'b0, busy1, slot1}, 32'h0);
    check("async fv", {31'b0, fv1}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel busy/slot", {28'b0, busy1, slot1}, 32'h0);

    // Gapped input
    send_frame("gapped", 8'h4B, 3, 1'b0);
    check_pub("gapped", {24'b0, ch1}, fv1);
    ack1 = 1'b1; tick(); ack1 = 1'b0;

    // Abort at slot 4, then a full frame of ones
    f0 = ferr_cnt; p0 = pub_cnt;
    for (int k = 0; k < 4; k++) send1(1'b0, k == 0, 1'b0);
    check("abort slot", {29'b0, slot1}, 32'd4);
    send_frame("abort", 8'hFF, 0, 1'b0);
    check_pub("abort", {24'b0, ch1}, fv1);
    tick();
    check("abort ferr_cnt", ferr_cnt - f0, 32'd1);
    check("abort pub_cnt", pub_cnt - p0, 32'd1);
    ack1 = 1'b1; tick(); ack1 = 1'b0;

    // Back-to-back frames with no ack: one overrun
    o0 = ovr_cnt;
    send_frame("b2b_a", 8'hA5, 0, 1'b0);
    check_pub("b2b_a", {24'b0, ch1}, fv1);
    send_frame("b2b_b", 8'h3C, 0, 1'b0);
    check_pub("b2b_b", {24'b0, ch1}, fv1);
    check("b2b ovr_pulse", {31'b0, ovr1}, 32'd1);
    tick();
    check("b2b ovr_cnt", ovr_cnt - o0, 32'd1);

    // Publish and ack together: no overrun, frame_valid stays set
    o0 = ovr_cnt;
    send_frame("simul", 8'h96, 0, 1'b1);
    check_pub("simul", {24'b0, ch1}, fv1);
    tick();
    check("simul ovr_cnt", ovr_cnt - o0, 32'd0);
    check("simul fv", {31'b0, fv1}, 32'd1);
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    check("simul acked", {31'b0, fv1}, 32'd0);

    // Dropped sample in IDLE
    send1(1'b1, 1'b0, 1'b0);
    check("drop pulse", {31'b0, derr1}, 32'd1);
    check("drop busy/slot", {28'b0, busy1, slot1}, 32'h0);
    tick();
    check("drop pulse_end", {31'b0, derr1}, 32'd0);

    // DW=4 frame, sample k = k
    for (int k = 0; k < 8; k++) begin
      din4 = 4'(k); sof4 = (k == 0); iv4 = 1'b1;
      tick();
    end
    iv4 = 1'b0; sof4 = 1'b0;
    exp_q.push_back(32'h7654_3210);
    check_pub("dw4", ch4, fv4);
    check("dw4 errs", {29'b0, ferr4, derr4, ovr4}, 32'd0);

    check("queue empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
